// File: rtl/pe_pkg.sv
// Shared definitions for the conv-array processing elements.
// Holds the overflow-mode enum, default operand widths, and the
// range-checked adder used by the weight-stationary and (future)
// output-stationary PEs.
package pe_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } ovf_mode_e;

    localparam int DEF_IFMAP_W     = 4;
    localparam int DEF_WEIGHT_W    = 4;
    localparam int DEF_OFMAP_W     = 8;
    localparam int DEF_NUM_WEIGHTS = 4;

    // Widest result sat_add can range-check without overflowing longint.
    localparam int SAT_MAX_W = 62;

    typedef struct packed {
        logic [63:0] sum;   // low 'width' bits carry the result
        logic        ovf;   // exact sum fell outside the result range
    } sat_res_t;

    // a and b arrive already sign- or zero-extended by the caller, so the
    // exact sum is available and compared against the width-bit range.
    function automatic sat_res_t sat_add(input longint    a,
                                         input longint    b,
                                         input logic      is_signed,
                                         input int        width,
                                         input ovf_mode_e mode);
        longint   s;
        longint   mx;
        longint   mn;
        sat_res_t r;
        s = a + b;
        if (is_signed) begin
            mx = (longint'(1) <<< (width - 1)) - 1;
            mn = -(longint'(1) <<< (width - 1));
        end else begin
            mx = (longint'(1) <<< width) - 1;
            mn = 0;
        end
        r.ovf = (s > mx) || (s < mn);
        if (r.ovf && (mode == SAT)) begin
            r.sum = (s > mx) ? mx : mn;
        end else begin
            r.sum = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_weight_bank.sv
// Double-buffered weight register file for the MAC PE.
// Ports:
//   clk, rst_n    : clock, asynchronous active-high reset
//   wr_en_i       : write wr_data_i into shadow[wr_addr_i]
//   wr_addr_i     : shadow write address (out-of-range writes dropped)
//   wr_data_i     : weight value to write
//   swap_i        : copy the whole shadow bank into the active bank
//   sel_i         : active entry to read (out of range reads as 0)
//   weight_o      : selected active weight
module mac_weight_bank
    import pe_pkg::*;
#(
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_W,
    parameter int NUM_WEIGHTS  = DEF_NUM_WEIGHTS,
    parameter int WADDR_WIDTH  = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [WADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [WEIGHT_WIDTH-1:0] wr_data_i,
    input  logic                    swap_i,
    input  logic [WADDR_WIDTH-1:0]  sel_i,
    output logic [WEIGHT_WIDTH-1:0] weight_o
);

    localparam logic [WADDR_WIDTH:0] NW = (WADDR_WIDTH + 1)'(NUM_WEIGHTS);

    logic [WEIGHT_WIDTH-1:0] shadow_q [NUM_WEIGHTS];
    logic [WEIGHT_WIDTH-1:0] active_q [NUM_WEIGHTS];

    // Swap samples the shadow bank before this edge's write, so a
    // simultaneous write only becomes active on a later swap.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_WEIGHTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_en_i && ({1'b0, wr_addr_i} < NW)) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
            if (swap_i) begin
                active_q <= shadow_q;
            end
        end
    end

    always_comb begin
        weight_o = '0;
        if ({1'b0, sel_i} < NW) begin
            weight_o = active_q[sel_i];
        end
    end

endmodule

// File: rtl/mac_pe_v2.sv
// Weight-stationary MAC processing element for the systolic conv array.
// ofmap_out = ofmap_in + ifmap_in * active[weight_sel], two enabled cycles
// later, with signed/unsigned operands and optional saturation.
// Ports:
//   clk, rst_n           : clock, asynchronous active-high reset
//   enable               : pipeline advance (0 holds all datapath regs)
//   valid_in             : ifmap_in/ofmap_in carry a real operand
//   signed_mode          : two's-complement operands and sum
//   weight_write_enable, weight_addr, weight_in : shadow bank write
//   weight_swap          : shadow -> active copy
//   weight_sel           : active entry used for this cycle's product
//   ifmap_in / ifmap_out : activation west in / east out (1 cycle)
//   ofmap_in / ofmap_out : partial sum north in / south out (2 cycles)
//   valid_out            : ofmap_out valid
//   ovf_clear / ovf_flag : sticky overflow flag and its clear
module mac_pe_v2
    import pe_pkg::*;
#(
    parameter int IFMAP_WIDTH  = DEF_IFMAP_W,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_W,
    parameter int OFMAP_WIDTH  = DEF_OFMAP_W,
    parameter int NUM_WEIGHTS  = DEF_NUM_WEIGHTS,
    parameter int SATURATE     = 1,
    parameter int WADDR_WIDTH  = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    valid_in,
    input  logic                    signed_mode,
    input  logic                    weight_write_enable,
    input  logic [WADDR_WIDTH-1:0]  weight_addr,
    input  logic [WEIGHT_WIDTH-1:0] weight_in,
    input  logic                    weight_swap,
    input  logic [WADDR_WIDTH-1:0]  weight_sel,
    input  logic [IFMAP_WIDTH-1:0]  ifmap_in,
    input  logic [OFMAP_WIDTH-1:0]  ofmap_in,
    input  logic                    ovf_clear,
    output logic [IFMAP_WIDTH-1:0]  ifmap_out,
    output logic [OFMAP_WIDTH-1:0]  ofmap_out,
    output logic                    valid_out,
    output logic                    ovf_flag
);

    localparam int        PW   = IFMAP_WIDTH + WEIGHT_WIDTH;
    localparam ovf_mode_e MODE = (SATURATE != 0) ? SAT : WRAP;

    if (OFMAP_WIDTH < PW) begin : g_bad_ofmap_w
        $error("mac_pe_v2: OFMAP_WIDTH must be >= IFMAP_WIDTH + WEIGHT_WIDTH");
    end
    if (OFMAP_WIDTH > SAT_MAX_W) begin : g_bad_ofmap_max
        $error("mac_pe_v2: OFMAP_WIDTH exceeds sat_add range");
    end
    if (NUM_WEIGHTS < 1) begin : g_bad_depth
        $error("mac_pe_v2: NUM_WEIGHTS must be >= 1");
    end

    logic [WEIGHT_WIDTH-1:0] w_sel;

    mac_weight_bank #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .NUM_WEIGHTS  (NUM_WEIGHTS),
        .WADDR_WIDTH  (WADDR_WIDTH)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (weight_write_enable),
        .wr_addr_i (weight_addr),
        .wr_data_i (weight_in),
        .swap_i    (weight_swap),
        .sel_i     (weight_sel),
        .weight_o  (w_sel)
    );

    logic [IFMAP_WIDTH-1:0] ifmap_p1_q;
    logic [PW-1:0]          prod_p1_q, prod_p1_d;
    logic [OFMAP_WIDTH-1:0] psum_p1_q;
    logic                   vld_p1_q;
    logic                   mode_p1_q;
    logic [OFMAP_WIDTH-1:0] ofmap_p2_q, ofmap_p2_d;
    logic                   vld_p2_q;
    logic                   ovf_q, ovf_d;

    logic signed [PW-1:0] prod_s;
    logic        [PW-1:0] prod_u;
    longint               prod_l;
    longint               psum_l;
    sat_res_t             res;
    logic                 unused_sum_hi;

    // ---- stage 1: product formed at full PW width so both modes are exact
    always_comb begin
        prod_s = $signed({{WEIGHT_WIDTH{ifmap_in[IFMAP_WIDTH-1]}}, ifmap_in})
               * $signed({{IFMAP_WIDTH{w_sel[WEIGHT_WIDTH-1]}}, w_sel});
        prod_u = {{WEIGHT_WIDTH{1'b0}}, ifmap_in} * {{IFMAP_WIDTH{1'b0}}, w_sel};
        prod_p1_d = signed_mode ? prod_s : prod_u;
    end

    // ---- stage 2: extend by the captured mode, then range-checked add
    always_comb begin
        if (mode_p1_q) begin
            prod_l = longint'($signed(prod_p1_q));
            psum_l = longint'($signed(psum_p1_q));
        end else begin
            prod_l = longint'(prod_p1_q);
            psum_l = longint'(psum_p1_q);
        end
        res        = sat_add(prod_l, psum_l, mode_p1_q, OFMAP_WIDTH, MODE);
        ofmap_p2_d = res.sum[OFMAP_WIDTH-1:0];

        // A new overflow outranks a clear arriving on the same edge.
        ovf_d = ovf_q;
        if (ovf_clear) begin
            ovf_d = 1'b0;
        end
        if (enable && vld_p1_q && res.ovf) begin
            ovf_d = 1'b1;
        end
    end

    assign unused_sum_hi = ^res.sum[63:OFMAP_WIDTH];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ifmap_p1_q <= '0;
            prod_p1_q  <= '0;
            psum_p1_q  <= '0;
            vld_p1_q   <= 1'b0;
            mode_p1_q  <= 1'b0;
            ofmap_p2_q <= '0;
            vld_p2_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (enable) begin
                ifmap_p1_q <= ifmap_in;
                prod_p1_q  <= prod_p1_d;
                psum_p1_q  <= ofmap_in;
                vld_p1_q   <= valid_in;
                mode_p1_q  <= signed_mode;
                ofmap_p2_q <= ofmap_p2_d;
                vld_p2_q   <= vld_p1_q;
            end
            ovf_q <= ovf_d;
        end
    end

    assign ifmap_out = ifmap_p1_q;
    assign ofmap_out = ofmap_p2_q;
    assign valid_out = vld_p2_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_mac_pe_v2.sv
module tb_mac_pe_v2;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       valid_in;
    logic       signed_mode;
    logic       we;
    logic [1:0] waddr;
    logic [3:0] win;
    logic       swap;
    logic [1:0] sel;
    logic [3:0] ifmap_in;
    logic [7:0] ofmap_in;
    logic       ovf_clear;

    logic [3:0] s_ifmap_out, w_ifmap_out;
    logic [7:0] s_ofmap_out, w_ofmap_out;
    logic       s_valid_out, w_valid_out;
    logic       s_ovf_flag,  w_ovf_flag;

    int n_vec;
    int n_err;

    // Saturating, 4-entry PE (default configuration).
    mac_pe_v2 u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .valid_in(valid_in),
        .signed_mode(signed_mode), .weight_write_enable(we),
        .weight_addr(waddr), .weight_in(win), .weight_swap(swap),
        .weight_sel(sel), .ifmap_in(ifmap_in), .ofmap_in(ofmap_in),
        .ovf_clear(ovf_clear), .ifmap_out(s_ifmap_out),
        .ofmap_out(s_ofmap_out), .valid_out(s_valid_out),
        .ovf_flag(s_ovf_flag)
    );

    // Wrapping, 3-entry PE: exposes out-of-range select/address at 2 bits.
    mac_pe_v2 #(.SATURATE(0), .NUM_WEIGHTS(3)) u_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .valid_in(valid_in),
        .signed_mode(signed_mode), .weight_write_enable(we),
        .weight_addr(waddr), .weight_in(win), .weight_swap(swap),
        .weight_sel(sel), .ifmap_in(ifmap_in), .ofmap_in(ofmap_in),
        .ovf_clear(ovf_clear), .ifmap_out(w_ifmap_out),
        .ofmap_out(w_ofmap_out), .valid_out(w_valid_out),
        .ovf_flag(w_ovf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: weights as integer arrays, each issued operand is
    // evaluated with ordinary integer arithmetic at issue time and then
    // simply delayed by the number of enabled edges.
    int m_sh [2][4];
    int m_ac [2][4];
    int m_if [2];
    int m_s1r[2];
    bit m_s1v[2];
    bit m_s1o[2];
    int m_or [2];
    bit m_ov [2];
    bit m_fl [2];

    function automatic int nw(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int sx(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[k][i] = 0;
                m_ac[k][i] = 0;
            end
            m_if[k] = 0; m_s1r[k] = 0; m_s1v[k] = 0; m_s1o[k] = 0;
            m_or[k] = 0; m_ov[k] = 0; m_fl[k] = 0;
        end
    endtask

    task automatic compute(input int k, output int r, output bit o);
        int w, iv, wv, pv, s, lo, hi;
        w = (int'(sel) < nw(k)) ? m_ac[k][sel] : 0;
        if (signed_mode) begin
            iv = sx(int'(ifmap_in), 4); wv = sx(w, 4); pv = sx(int'(ofmap_in), 8);
            lo = -128; hi = 127;
        end else begin
            iv = int'(ifmap_in); wv = w; pv = int'(ofmap_in);
            lo = 0; hi = 255;
        end
        s = pv + iv * wv;
        o = (s > hi) || (s < lo);
        if (o && (k == 0)) r = ((s > hi) ? hi : lo) & 255;
        else               r = s & 255;
    endtask

    task automatic model_edge();
        int r;
        bit o;
        for (int k = 0; k < 2; k++) begin
            if (enable && m_s1v[k] && m_s1o[k]) m_fl[k] = 1'b1;
            else if (ovf_clear)                  m_fl[k] = 1'b0;
            if (enable) begin
                m_or[k] = m_s1r[k];
                m_ov[k] = m_s1v[k];
                compute(k, r, o);
                m_s1r[k] = r;
                m_s1o[k] = o;
                m_s1v[k] = valid_in;
                m_if[k]  = int'(ifmap_in);
            end
            if (swap) for (int i = 0; i < 4; i++) m_ac[k][i] = m_sh[k][i];
            if (we && (int'(waddr) < nw(k))) m_sh[k][waddr] = int'(win);
        end
    endtask

    task automatic check_all();
        chk("sat.ifmap", 32'(s_ifmap_out), 32'(m_if[0]));
        chk("sat.ofmap", 32'(s_ofmap_out), 32'(m_or[0]));
        chk("sat.valid", 32'(s_valid_out), 32'(m_ov[0]));
        chk("sat.ovf",   32'(s_ovf_flag),  32'(m_fl[0]));
        chk("wrap.ifmap", 32'(w_ifmap_out), 32'(m_if[1]));
        chk("wrap.ofmap", 32'(w_ofmap_out), 32'(m_or[1]));
        chk("wrap.valid", 32'(w_valid_out), 32'(m_ov[1]));
        chk("wrap.ovf",   32'(w_ovf_flag),  32'(m_fl[1]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        enable = 1'b1; valid_in = 1'b0; signed_mode = 1'b0; we = 1'b0;
        waddr = 2'd0; win = 4'd0; swap = 1'b0; sel = 2'd0;
        ifmap_in = 4'd0; ofmap_in = 8'd0; ovf_clear = 1'b0;
    endtask

    task automatic load_weight(input logic [1:0] a, input logic [3:0] w);
        idle(); we = 1'b1; waddr = a; win = w; step();
        idle(); swap = 1'b1; step();
        idle();
    endtask

    task automatic issue(input logic sm, input logic [1:0] s, input logic [3:0] ifm,
                         input logic [7:0] ofm);
        idle(); valid_in = 1'b1; signed_mode = sm; sel = s;
        ifmap_in = ifm; ofmap_in = ofm; step();
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b0;

        // Reset with valid data in flight.
        load_weight(2'd0, 4'd3);
        issue(1'b0, 2'd0, 4'd2, 8'd1);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_ofmap_now", 32'(s_ofmap_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(); step();
        chk("rst_vld_after", 32'(s_valid_out), 32'd0);
        step();
        chk("rst_ofmap_after", 32'(s_ofmap_out), 32'd0);

        // Basic MAC: 1 + 2*3.
        load_weight(2'd0, 4'd3);
        issue(1'b0, 2'd0, 4'd2, 8'd1);
        chk("basic_ifmap", 32'(s_ifmap_out), 32'd2);
        step();
        chk("basic_ofmap", 32'(s_ofmap_out), 32'd7);
        chk("basic_vld",   32'(s_valid_out), 32'd1);

        // Shadow write without swap, then swap, then write+swap together.
        we = 1'b1; waddr = 2'd0; win = 4'd5; step(); idle();
        issue(1'b0, 2'd0, 4'd2, 8'd0); step();
        chk("noswap_ofmap", 32'(s_ofmap_out), 32'd6);
        swap = 1'b1; step(); idle();
        issue(1'b0, 2'd0, 4'd2, 8'd0); step();
        chk("swap_ofmap", 32'(s_ofmap_out), 32'd10);
        we = 1'b1; waddr = 2'd0; win = 4'd9; swap = 1'b1; step(); idle();
        issue(1'b0, 2'd0, 4'd2, 8'd0); step();
        chk("wrswap_ofmap", 32'(s_ofmap_out), 32'd10);

        // Signed: 4 + 3*(-2) = -2; then -8*-8 + 127 clamps.
        load_weight(2'd0, 4'hE);
        issue(1'b1, 2'd0, 4'd3, 8'd4); step();
        chk("sgn_ofmap", 32'(s_ofmap_out), 32'hFE);
        chk("sgn_noovf", 32'(s_ovf_flag), 32'd0);
        load_weight(2'd0, 4'h8);
        issue(1'b1, 2'd0, 4'h8, 8'h7F); step();
        chk("sgn_clamp", 32'(s_ofmap_out), 32'h7F);
        chk("sgn_ovf",   32'(s_ovf_flag), 32'd1);
        ovf_clear = 1'b1; step(); idle();
        chk("sgn_clr", 32'(s_ovf_flag), 32'd0);

        // Unsigned: 100 + 15*15 = 325 -> 255 saturated / 69 wrapped.
        load_weight(2'd0, 4'd15);
        issue(1'b0, 2'd0, 4'd15, 8'd100); step();
        chk("uns_sat",      32'(s_ofmap_out), 32'd255);
        chk("uns_wrap",     32'(w_ofmap_out), 32'd69);
        chk("uns_wrap_ovf", 32'(w_ovf_flag),  32'd1);
        ovf_clear = 1'b1; step(); idle();
        chk("uns_clr", 32'(w_ovf_flag), 32'd0);

        // Stall mid-pipeline.
        load_weight(2'd0, 4'd3);
        step();
        issue(1'b0, 2'd0, 4'd2, 8'd1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_vld",   32'(s_valid_out), 32'd0);
            chk("stall_ifmap", 32'(s_ifmap_out), 32'd2);
        end
        idle(); step();
        chk("resume_ofmap", 32'(s_ofmap_out), 32'd7);
        chk("resume_vld",   32'(s_valid_out), 32'd1);

        // Out-of-range select on the 3-entry PE passes ofmap_in through.
        load_weight(2'd3, 4'd7);
        issue(1'b0, 2'd3, 4'd5, 8'd42); step();
        chk("oor_ofmap", 32'(w_ofmap_out), 32'd42);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            enable      = ($urandom_range(0, 9) < 8);
            valid_in    = $urandom_range(0, 1);
            signed_mode = $urandom_range(0, 1);
            we          = ($urandom_range(0, 9) < 4);
            waddr       = 2'($urandom_range(0, 3));
            win         = 4'($urandom);
            swap        = ($urandom_range(0, 9) < 2);
            sel         = 2'($urandom_range(0, 3));
            ifmap_in    = 4'($urandom);
            ofmap_in    = 8'($urandom);
            ovf_clear   = ($urandom_range(0, 9) < 1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
